// File: rtl/serial_adder_spec_checker.sv
// Bit-serial adder checker: streams two operands LSB-first and compares each candidate bit
// against the running sum (optionally the final carry). Optional early exit: SPEC_CHECK_EARLY_EXIT_EN.
module serial_adder_spec_checker #(
    parameter int WIDTH           = 8,
    parameter bit CHECK_CARRY_OUT = 1'b1,
    localparam int IDX_W          = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             x_a,
    input  logic             x_b,
    input  logic             i_s,
    output logic             busy,
    output logic             done,
    output logic             out,
    output logic [IDX_W-1:0] err_idx
);

    typedef enum logic [1:0] {IDLE, RUN, CARRY, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] CARRY_IDX = IDX_W'(WIDTH);

    state_t             state_q, state_d;
    logic               carry_q, carry_d;
    logic               match_q, match_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               out_q, out_d;
    logic [IDX_W-1:0]   err_idx_q, err_idx_d;
    logic               beat_ok;
    logic               sum_bit;

    assign beat_ok = in_valid & in_ready_q;
    assign sum_bit = x_a ^ x_b ^ carry_q;

    always_comb begin
        state_d   = state_q;
        carry_d   = carry_q;
        match_d   = match_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        err_idx_d = err_idx_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    carry_d   = 1'b0;
                    cnt_d     = '0;
                    out_d     = 1'b0;
                    err_idx_d = '0;
                    match_d   = 1'b1;
                end
            end
            RUN: begin
                if (beat_ok) begin
                    carry_d = (x_a & x_b) | (carry_q & (x_a ^ x_b));
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = CHECK_CARRY_OUT ? CARRY : DONE;
                    end
                    if ((sum_bit != i_s) && match_q) begin
                        match_d   = 1'b0;
                        err_idx_d = cnt_q;
`ifdef SPEC_CHECK_EARLY_EXIT_EN
                        state_d   = DONE;
`endif
                    end
                end
            end
            CARRY: begin
                // Operand bits are don't-care here; only the candidate carry matters.
                if (beat_ok) begin
                    if ((i_s != carry_q) && match_q) begin
                        match_d   = 1'b0;
                        err_idx_d = CARRY_IDX;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake/status outputs are registered decodes of the next state.
        in_ready_d = (state_d == RUN) || (state_d == CARRY);
        busy_d     = in_ready_d;
        done_d     = (state_d == DONE);
        if (state_d == DONE) begin
            out_d = match_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            carry_q    <= 1'b0;
            match_q    <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            out_q      <= 1'b0;
            err_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            carry_q    <= carry_d;
            match_q    <= match_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            out_q      <= out_d;
            err_idx_q  <= err_idx_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign out      = out_q;
    assign err_idx  = err_idx_q;

endmodule

// File: tb/tb_serial_adder_spec_checker.sv
// Table-driven bench for serial_adder_spec_checker (WIDTH=4, carry beat enabled),
// plus hand sequences for reset mid-frame and start during DONE.
module tb_serial_adder_spec_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       x_a;
    logic       x_b;
    logic       i_s;
    logic       busy;
    logic       done;
    logic       out;
    logic [2:0] err_idx;

    int n_vec = 0;
    int n_mis = 0;

    serial_adder_spec_checker #(
        .WIDTH           (4),
        .CHECK_CARRY_OUT (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_a      (x_a),
        .x_b      (x_b),
        .i_s      (i_s),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .err_idx  (err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] s;
        logic       c;
        int         gap;
        bit         mid_start;
        bit         valid_at_start;
        logic       exp_out;
        int         exp_err;
        int         exp_lat;
        int         exp_beats;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Drives one frame; returns at the negedge where done is seen (start may be left high).
    task automatic run_frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                             input logic c, input int gap, input bit mid_start,
                             input bit valid_at_start, input bit start_at_done,
                             output logic o_out, output int o_err, output int lat,
                             output int beats, output bit got);
        int k = 0;
        int g = 0;
        got   = 1'b0;
        o_out = 1'b0;
        o_err = -1;
        lat   = -1;
        @(negedge clk);
        start    = 1'b1;
        in_valid = valid_at_start;
        x_a      = 1'b1;
        x_b      = 1'b1;
        i_s      = 1'b0;
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b0;
            if (done) begin
                got   = 1'b1;
                o_out = out;
                o_err = int'(err_idx);
                lat   = cyc;
                if (start_at_done) start = 1'b1;
            end else if (in_ready) begin
                if (k == 2 && g < gap) begin
                    g++;
                    if (mid_start && g == 2) start = 1'b1;
                    x_a = 1'b1;
                    x_b = 1'b1;
                    i_s = 1'b1;
                end else begin
                    in_valid = 1'b1;
                    x_a      = (k < 4) ? a[k[1:0]] : 1'b1;
                    x_b      = (k < 4) ? b[k[1:0]] : 1'b1;
                    i_s      = (k < 4) ? s[k[1:0]] : c;
                    k++;
                end
            end
        end
        beats = k;
    endtask

    initial begin
        logic r_out;
        int   r_err;
        int   r_lat;
        int   r_beats;
        bit   r_got;
        int   e_lat;
        int   e_beats;

        //          a        b        s        c     gap mid vas out err lat beats
        vecs[0]  = '{4'd5,  4'd3,  4'b1000, 1'b0, 0, 0, 0, 1'b1, 0, 6, 5};
        vecs[1]  = '{4'd5,  4'd3,  4'b1100, 1'b0, 0, 0, 0, 1'b0, 2, 6, 5};
        vecs[2]  = '{4'd15, 4'd1,  4'b0000, 1'b0, 0, 0, 0, 1'b0, 4, 6, 5};
        vecs[3]  = '{4'd15, 4'd1,  4'b0000, 1'b1, 0, 0, 0, 1'b1, 0, 6, 5};
        vecs[4]  = '{4'd5,  4'd3,  4'b1000, 1'b0, 3, 1, 0, 1'b1, 0, 9, 5};
        vecs[5]  = '{4'd5,  4'd3,  4'b0110, 1'b1, 0, 0, 0, 1'b0, 1, 6, 5};
        vecs[6]  = '{4'd0,  4'd0,  4'b0000, 1'b0, 0, 0, 0, 1'b1, 0, 6, 5};
        vecs[7]  = '{4'd9,  4'd7,  4'b0000, 1'b1, 0, 0, 1, 1'b1, 0, 6, 5};
        vecs[8]  = '{4'd6,  4'd5,  4'b1011, 1'b0, 0, 0, 0, 1'b1, 0, 6, 5};
        vecs[9]  = '{4'd6,  4'd5,  4'b1011, 1'b1, 0, 0, 0, 1'b0, 4, 6, 5};
        vecs[10] = '{4'd3,  4'd3,  4'b0111, 1'b0, 0, 0, 0, 1'b0, 0, 6, 5};
        vecs[11] = '{4'd10, 4'd12, 4'b0110, 1'b1, 2, 0, 0, 1'b1, 0, 8, 5};

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        x_a      = 1'b0;
        x_b      = 1'b0;
        i_s      = 1'b0;
        #3;
        check("reset in_ready", int'(in_ready), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset out", int'(out), 0);
        check("reset err_idx", int'(err_idx), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            e_lat   = vecs[i].exp_lat;
            e_beats = vecs[i].exp_beats;
`ifdef SPEC_CHECK_EARLY_EXIT_EN
            if (!vecs[i].exp_out && vecs[i].exp_err < 4) begin
                e_beats = vecs[i].exp_err + 1;
                e_lat   = vecs[i].exp_err + 2;
            end
`endif
            run_frame(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, vecs[i].gap,
                      vecs[i].mid_start, vecs[i].valid_at_start, 1'b0,
                      r_out, r_err, r_lat, r_beats, r_got);
            check($sformatf("v%0d done_seen", i), int'(r_got), 1);
            check($sformatf("v%0d out", i), int'(r_out), int'(vecs[i].exp_out));
            check($sformatf("v%0d err_idx", i), r_err, vecs[i].exp_err);
            check($sformatf("v%0d latency", i), r_lat, e_lat);
            check($sformatf("v%0d beats", i), r_beats, e_beats);
            @(negedge clk);
            check($sformatf("v%0d post done", i), int'(done), 0);
            check($sformatf("v%0d post in_ready", i), int'(in_ready), 0);
            check($sformatf("v%0d post busy", i), int'(busy), 0);
        end

        // start raised in the DONE cycle must be ignored; result held afterwards
        run_frame(4'd5, 4'd3, 4'b1000, 1'b0, 0, 0, 0, 1'b1,
                  r_out, r_err, r_lat, r_beats, r_got);
        check("sd out", int'(r_out), 1);
        @(negedge clk);
        start = 1'b0;
        check("sd busy after", int'(busy), 0);
        repeat (3) @(negedge clk);
        check("sd busy idle", int'(busy), 0);
        check("sd out held", int'(out), 1);

        // reset after beat 2 abandons the frame
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst start clears out", int'(out), 0);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            x_a      = (k == 0 || k == 2);
            x_b      = (k < 2);
            i_s      = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("rst busy before", int'(busy), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst in_ready", int'(in_ready), 0);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst out", int'(out), 0);
        check("rst err_idx", int'(err_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (done) seen++;
            end
            check("rst no done", seen, 0);
        end
        run_frame(4'd5, 4'd3, 4'b1000, 1'b0, 0, 0, 0, 1'b0,
                  r_out, r_err, r_lat, r_beats, r_got);
        check("after rst done_seen", int'(r_got), 1);
        check("after rst out", int'(r_out), 1);
        check("after rst err_idx", r_err, 0);
        check("after rst latency", r_lat, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
